// File: rtl/hazard_pkg.sv
// Shared encodings for the decode-stage hazard controller: FSM states, forward-select
// codes and the architecturally special register numbers.
package hazard_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEM     = 2'd1;
    localparam logic [1:0] FWD_WB      = 2'd2;

    localparam logic [1:0] FWDG_RD1    = 2'd0;
    localparam logic [1:0] FWDG_RA_MEM = 2'd1;
    localparam logic [1:0] FWDG_FWD    = 2'd2;
    localparam logic [1:0] FWDG_WB     = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/id_forward_select.sv
// Producer-match and forward-priority logic for one decode-stage source operand.
// JUMP_PATH selects the jr/jalr target encoding, which adds the in-flight jal link value.
module id_forward_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit JUMP_PATH  = 1'b0
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  mem_reg_write,
    input  logic                  mem_jal,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic                  ex_match,
    output logic                  mem_match,
    output logic [1:0]            fwd_sel
);

    logic src_live_s;
    logic wb_match_s;

    // Match against each producer stage; $0 is hardwired and never matches.
    always_comb begin
        src_live_s = (src != REG_ADDR_W'(REG_ZERO));
        ex_match   = ex_reg_write  & (ex_write_reg  == src) & src_live_s;
        mem_match  = mem_reg_write & (mem_write_reg == src) & src_live_s;
        wb_match_s = wb_reg_write  & (wb_write_reg  == src) & src_live_s;
        if (JUMP_PATH) begin
            if (mem_jal && (src == REG_ADDR_W'(REG_RA))) begin
                fwd_sel = FWDG_RA_MEM;
            end else if (mem_match) begin
                fwd_sel = FWDG_FWD;
            end else if (wb_match_s) begin
                fwd_sel = FWDG_WB;
            end else begin
                fwd_sel = FWDG_RD1;
            end
        end else begin
            if (mem_match) begin
                fwd_sel = FWD_MEM;
            end else if (wb_match_s) begin
                fwd_sel = FWD_WB;
            end else begin
                fwd_sel = FWD_REGFILE;
            end
        end
    end

endmodule

// File: rtl/id_hazard_controller.sv
// Decode-stage hazard controller: forwarding selects, PC/IF-ID stalls, bubbles and redirects.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module id_hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRt,
    input  logic                  ID_Branch,
    input  logic                  ID_JumpReg,
    input  logic                  ID_Jump,
    input  logic                  BranchOut,
    input  logic                  EX_RegWrite,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    input  logic                  MEM_RegWrite,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_Jal,
    input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteReg,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  FlushControl,
    output logic                  IFFlush,
    output logic [1:0]            ForwardE,
    output logic [1:0]            ForwardF,
    output logic [1:0]            ForwardG,
    output logic [PERF_W-1:0]     StallCount,
    output logic [PERF_W-1:0]     FlushCount
);

    logic [0:0] state_q, state_d;
    logic       cnt_q, cnt_d;
    logic       rs_ex_s, rs_mem_s, rt_ex_s, rt_mem_s, jr_ex_s, jr_mem_s;
    logic [1:0] rs_fwd_s, rt_fwd_s, jr_fwd_s;
    logic       resolve_s, ex_hit_resolve_s, mem_hit_resolve_s, ex_hit_use_s;
    logic [1:0] hazard_n_s;
    logic       stall_s, ifflush_s;

    id_forward_select #(.REG_ADDR_W(REG_ADDR_W), .JUMP_PATH(1'b0)) u_fwd_rs (
        .src(ID_Rs), .ex_reg_write(EX_RegWrite), .ex_write_reg(EX_WriteReg),
        .mem_reg_write(MEM_RegWrite), .mem_jal(MEM_Jal), .mem_write_reg(MEM_WriteReg),
        .wb_reg_write(WB_RegWrite), .wb_write_reg(WB_WriteReg),
        .ex_match(rs_ex_s), .mem_match(rs_mem_s), .fwd_sel(rs_fwd_s)
    );

    id_forward_select #(.REG_ADDR_W(REG_ADDR_W), .JUMP_PATH(1'b0)) u_fwd_rt (
        .src(ID_Rt), .ex_reg_write(EX_RegWrite), .ex_write_reg(EX_WriteReg),
        .mem_reg_write(MEM_RegWrite), .mem_jal(MEM_Jal), .mem_write_reg(MEM_WriteReg),
        .wb_reg_write(WB_RegWrite), .wb_write_reg(WB_WriteReg),
        .ex_match(rt_ex_s), .mem_match(rt_mem_s), .fwd_sel(rt_fwd_s)
    );

    // Jump-target instance; its Rs matches also feed the in-ID branch/jr resolution hazard.
    id_forward_select #(.REG_ADDR_W(REG_ADDR_W), .JUMP_PATH(1'b1)) u_fwd_jr (
        .src(ID_Rs), .ex_reg_write(EX_RegWrite), .ex_write_reg(EX_WriteReg),
        .mem_reg_write(MEM_RegWrite), .mem_jal(MEM_Jal), .mem_write_reg(MEM_WriteReg),
        .wb_reg_write(WB_RegWrite), .wb_write_reg(WB_WriteReg),
        .ex_match(jr_ex_s), .mem_match(jr_mem_s), .fwd_sel(jr_fwd_s)
    );

    // Number of stall cycles the ID instruction needs before its operands are reachable.
    always_comb begin
        resolve_s         = ID_Branch | ID_JumpReg;
        ex_hit_resolve_s  = jr_ex_s  | (ID_UsesRt & rt_ex_s);
        mem_hit_resolve_s = jr_mem_s | (ID_UsesRt & rt_mem_s);
        ex_hit_use_s      = rs_ex_s  | (ID_UsesRt & rt_ex_s);
        if (resolve_s && EX_MemRead && ex_hit_resolve_s) begin
            hazard_n_s = 2'd2;
        end else if (resolve_s && ex_hit_resolve_s) begin
            hazard_n_s = 2'd1;
        end else if (resolve_s && MEM_MemRead && mem_hit_resolve_s) begin
            hazard_n_s = 2'd1;
        end else if (!resolve_s && EX_MemRead && ex_hit_use_s) begin
            hazard_n_s = 2'd1;
        end else begin
            hazard_n_s = 2'd0;
        end
    end

    // Stall sequencer: STALL holds the pipeline for the extra cycle of a load feeding a branch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard_n_s != 2'd0) begin
                    stall_s = 1'b1;
                    if (hazard_n_s == 2'd2) begin
                        state_d = ST_STALL;
                        cnt_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_STALL: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_d == 1'b0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 1'b0;
                stall_s = 1'b0;
            end
        endcase
    end

    // Output decode; an active reset forces the bubble/hold values immediately.
    always_comb begin
        ifflush_s = ~stall_s & ((ID_Branch & BranchOut) | ID_Jump);
        if (!Reset_n) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            FlushControl = 1'b1;
            IFFlush      = 1'b0;
            ForwardE     = FWD_REGFILE;
            ForwardF     = FWD_REGFILE;
            ForwardG     = FWDG_RD1;
        end else begin
            PCWrite      = ~stall_s;
            IFIDWrite    = ~stall_s;
            FlushControl = stall_s;
            IFFlush      = ifflush_s;
            ForwardE     = rs_fwd_s;
            ForwardF     = rt_fwd_s;
            ForwardG     = jr_fwd_s;
        end
    end

    // Sequencer state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_count_q, stall_count_d;
    logic [PERF_W-1:0] flush_count_q, flush_count_d;

    // Free-running event counters, wrapping naturally at 2^PERF_W.
    always_comb begin
        stall_count_d = stall_count_q + (stall_s   ? PERF_W'(1) : PERF_W'(0));
        flush_count_d = flush_count_q + (ifflush_s ? PERF_W'(1) : PERF_W'(0));
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_count_q <= {PERF_W{1'b0}};
            flush_count_q <= {PERF_W{1'b0}};
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign StallCount = stall_count_q;
    assign FlushCount = flush_count_q;
`else
    assign StallCount = {PERF_W{1'b0}};
    assign FlushCount = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Bench for id_hazard_controller: directed pipeline scenarios plus randomized traffic
// checked against a stall-budget reference model.
module tb_id_hazard_controller;

    logic        Clk, Reset_n;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
    logic        ID_UsesRt, ID_Branch, ID_JumpReg, ID_Jump, BranchOut;
    logic        EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, MEM_Jal, WB_RegWrite;
    logic        PCWrite, IFIDWrite, FlushControl, IFFlush;
    logic [1:0]  ForwardE, ForwardF, ForwardG;
    logic [31:0] StallCount, FlushCount;

`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    id_hazard_controller #(.REG_ADDR_W(5), .PERF_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_JumpReg(ID_JumpReg), .ID_Jump(ID_Jump), .BranchOut(BranchOut),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_Jal(MEM_Jal),
        .MEM_WriteReg(MEM_WriteReg), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .FlushControl(FlushControl), .IFFlush(IFFlush),
        .ForwardE(ForwardE), .ForwardF(ForwardF), .ForwardG(ForwardG),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    wire [9:0] obs_vec = {PCWrite, IFIDWrite, FlushControl, IFFlush, ForwardE, ForwardF, ForwardG};

    int n_pass  = 0;
    int n_total = 0;
    int m_rem   = 0;      // stall cycles still owed by the instruction held in ID
    int m_stall = 0;
    int m_flush = 0;

    function automatic bit writes(bit we, logic [4:0] dst, logic [4:0] r);
        return we && (dst == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_ef(logic [4:0] r);
        if (writes(MEM_RegWrite, MEM_WriteReg, r)) return 2'd1;
        if (writes(WB_RegWrite, WB_WriteReg, r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] fwd_g();
        if (MEM_Jal && ID_Rs == 5'd31) return 2'd1;
        if (writes(MEM_RegWrite, MEM_WriteReg, ID_Rs)) return 2'd2;
        if (writes(WB_RegWrite, WB_WriteReg, ID_Rs)) return 2'd3;
        return 2'd0;
    endfunction

    function automatic int hazard_n();
        bit ex_hit, mem_hit;
        ex_hit  = writes(EX_RegWrite, EX_WriteReg, ID_Rs) ||
                  (ID_UsesRt && writes(EX_RegWrite, EX_WriteReg, ID_Rt));
        mem_hit = writes(MEM_RegWrite, MEM_WriteReg, ID_Rs) ||
                  (ID_UsesRt && writes(MEM_RegWrite, MEM_WriteReg, ID_Rt));
        if (ID_Branch || ID_JumpReg) begin
            if (ex_hit) return EX_MemRead ? 2 : 1;
            if (MEM_MemRead && mem_hit) return 1;
            return 0;
        end
        return (EX_MemRead && ex_hit) ? 1 : 0;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic st, fl;
        if (!Reset_n) return 10'b0010_000000;
        st = (m_rem > 0) || (hazard_n() > 0);
        fl = !st && ((ID_Branch && BranchOut) || ID_Jump);
        return {!st, !st, st, fl, fwd_ef(ID_Rs), fwd_ef(ID_Rt), fwd_g()};
    endfunction

    task automatic tick();
        int n;
        bit st, fl;
        n  = hazard_n();
        st = (m_rem > 0) || (n > 0);
        fl = !st && ((ID_Branch && BranchOut) || ID_Jump);
        @(posedge Clk);
        if (Reset_n) begin
            if (st) m_stall++;
            if (fl) m_flush++;
            if (m_rem > 0) m_rem--;
            else if (n > 0) m_rem = n - 1;
        end
        #1;
    endtask

    task automatic set_idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_Branch = 1'b0; ID_JumpReg = 1'b0;
        ID_Jump = 1'b0; BranchOut = 1'b0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
        EX_WriteReg = 5'd0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_Jal = 1'b0;
        MEM_WriteReg = 5'd0; WB_RegWrite = 1'b0; WB_WriteReg = 5'd0;
    endtask

    task automatic test_reset();
        set_idle();
        Reset_n = 1'b0;
        #3;
        n_total++;
        if (obs_vec !== 10'b0010_000000) $display("FAIL reset_outputs: got %b expected %b", obs_vec, 10'b0010_000000);
        else n_pass++;
        n_total++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0)
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCount, FlushCount);
        else n_pass++;
        #9 Reset_n = 1'b1;
        @(negedge Clk);
        n_total++;
        if (obs_vec !== 10'b1100_000000) $display("FAIL reset_release_run: got %b expected %b", obs_vec, 10'b1100_000000);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        ID_Rs = 5'd8; ID_Rt = 5'd10; ID_UsesRt = 1'b1;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
        @(negedge Clk);
        n_total++;
        if (PCWrite !== 1'b0 || FlushControl !== 1'b1 || obs_vec !== exp_vec())
            $display("FAIL load_use_stall: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
        MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd8;
        @(negedge Clk);
        n_total++;
        if (ForwardE !== 2'd1 || PCWrite !== 1'b1 || obs_vec !== exp_vec())
            $display("FAIL load_use_forward: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_after_load(input bit taken);
        set_idle();
        ID_Rs = 5'd8; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Branch = 1'b1; BranchOut = taken;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_total++;
            if (FlushControl !== (c < 2) || IFFlush !== (c == 2 && taken) || obs_vec !== exp_vec())
                $display("FAIL branch_load_c%0d: got %b expected %b", c, obs_vec, exp_vec());
            else n_pass++;
            tick();
            if (c == 0) begin
                EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
                MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd8;
            end else begin
                MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;
                WB_RegWrite = 1'b1; WB_WriteReg = 5'd8;
            end
        end
        n_total++;
        if (ForwardE !== 2'd2) $display("FAIL branch_load_fwd: got %0d expected 2", ForwardE);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_after_alu();
        set_idle();
        ID_Rs = 5'd8; ID_Rt = 5'd9; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
        EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
        @(negedge Clk);
        n_total++;
        if (PCWrite !== 1'b0 || obs_vec !== exp_vec())
            $display("FAIL branch_alu_stall: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
        EX_RegWrite = 1'b0; MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd8;
        @(negedge Clk);
        n_total++;
        if (ForwardE !== 2'd1 || PCWrite !== 1'b1 || obs_vec !== exp_vec())
            $display("FAIL branch_alu_fwd: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
    endtask

    task automatic test_jr_after_jal();
        set_idle();
        ID_Rs = 5'd31; ID_JumpReg = 1'b1; ID_Jump = 1'b1;
        MEM_RegWrite = 1'b1; MEM_Jal = 1'b1; MEM_WriteReg = 5'd31;
        @(negedge Clk);
        n_total++;
        if (ForwardG !== 2'd1 || IFFlush !== 1'b1 || PCWrite !== 1'b1 || obs_vec !== exp_vec())
            $display("FAIL jr_jal: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
        set_idle();
        @(negedge Clk);
        n_total++;
        if (IFFlush !== 1'b0) $display("FAIL jr_jal_one_shot: got %b expected 0", IFFlush);
        else n_pass++;
        tick();
    endtask

    task automatic test_priority_and_zero();
        set_idle();
        ID_Rs = 5'd10; ID_Rt = 5'd10; ID_UsesRt = 1'b1;
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd10; WB_RegWrite = 1'b1; WB_WriteReg = 5'd10;
        @(negedge Clk);
        n_total++;
        if (ForwardE !== 2'd1 || ForwardF !== 2'd1 || ForwardG !== 2'd2 || obs_vec !== exp_vec())
            $display("FAIL mem_over_wb: got %b expected %b", obs_vec, exp_vec());
        else n_pass++;
        tick();
        set_idle();
        ID_Branch = 1'b1; ID_UsesRt = 1'b1;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1;
        WB_RegWrite = 1'b1;
        @(negedge Clk);
        n_total++;
        if (obs_vec !== 10'b1100_000000) $display("FAIL zero_reg: got %b expected %b", obs_vec, 10'b1100_000000);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] pool [5];
        pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2; pool[3] = 5'd3; pool[4] = 5'd31;
        for (int i = 0; i < 400; i++) begin
            ID_Rs = pool[$urandom_range(0, 4)];     ID_Rt = pool[$urandom_range(0, 4)];
            ID_UsesRt = 1'($urandom_range(0, 1));   ID_Branch = 1'($urandom_range(0, 1));
            ID_JumpReg = ($urandom_range(0, 3) == 0);
            ID_Jump = ID_JumpReg || ($urandom_range(0, 5) == 0);
            BranchOut = 1'($urandom_range(0, 1));
            EX_RegWrite = 1'($urandom_range(0, 1)); EX_MemRead = 1'($urandom_range(0, 1));
            EX_WriteReg = pool[$urandom_range(0, 4)];
            MEM_RegWrite = 1'($urandom_range(0, 1)); MEM_MemRead = 1'($urandom_range(0, 1));
            MEM_Jal = ($urandom_range(0, 4) == 0);  MEM_WriteReg = pool[$urandom_range(0, 4)];
            WB_RegWrite = 1'($urandom_range(0, 1)); WB_WriteReg = pool[$urandom_range(0, 4)];
            @(negedge Clk);
            n_total++;
            if (obs_vec !== exp_vec()) $display("FAIL random_%0d: got %b expected %b", i, obs_vec, exp_vec());
            else n_pass++;
            tick();
        end
        n_total++;
        if (StallCount !== (PERF_ON ? 32'(m_stall) : 32'd0))
            $display("FAIL stall_count: got %0d expected %0d", StallCount, PERF_ON ? m_stall : 0);
        else n_pass++;
        n_total++;
        if (FlushCount !== (PERF_ON ? 32'(m_flush) : 32'd0))
            $display("FAIL flush_count: got %0d expected %0d", FlushCount, PERF_ON ? m_flush : 0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        ID_Rs = 5'd5; ID_JumpReg = 1'b1; ID_Jump = 1'b1;
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd5;
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd5;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        m_rem = 0; m_stall = 0; m_flush = 0;
        n_total++;
        if (obs_vec !== 10'b0010_000000 || StallCount !== 32'd0 || FlushCount !== 32'd0)
            $display("FAIL reset_mid_stall: got %b/%0d expected %b/0", obs_vec, StallCount, 10'b0010_000000);
        else n_pass++;
        @(negedge Clk);
        set_idle();
        Reset_n = 1'b1;
        #1;
        n_total++;
        if (obs_vec !== 10'b1100_000000) $display("FAIL post_reset_run: got %b expected %b", obs_vec, 10'b1100_000000);
        else n_pass++;
        tick();
        n_total++;
        if (StallCount !== 32'd0) $display("FAIL post_reset_count: got %0d expected 0", StallCount);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_after_load(1'b1);
        test_branch_after_load(1'b0);
        test_branch_after_alu();
        test_jr_after_jal();
        test_priority_and_zero();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
